interp_mux_sequencer: RTL
=========================

INTERP_MUX_SEQUENCER -- requirements
Module: interp_mux_sequencer

Interface
REQ-001 SHALL have parameter NUM_PIXEL, default 8: block width in pixels, which sets the select ranges.
REQ-002 SHALL have parameter SEL_W, default 8: width of the mux select and tag buses.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request to sequence one block; sampled only in IDLE.
REQ-006 SHALL have port phase_en, input, 5 bits: phase enables. Bit0 = INT_ROW, bit1 = INT_COL, bit2 = HALF_A, bit3 = HALF_B, bit4 = HALF_C.
REQ-007 SHALL have port tag_in, input, SEL_W bits: block tag, latched on start.
REQ-008 SHALL have port abort, input, 1 bit: synchronous cancel of the current block.
REQ-009 SHALL have port ready, input, 1 bit: downstream filter can accept an entry this cycle.
REQ-010 SHALL have port sel, output, SEL_W bits: select driven to the input row/column mux.
REQ-011 SHALL have port sel_valid, output, 1 bit: sel holds a pending entry.
REQ-012 SHALL have port out_valid, output, 1 bit: the mux output register holds a newly accepted entry.
REQ-013 SHALL have port out_phase, output, 3 bits: phase code of the out_valid entry (0..4).
REQ-014 SHALL have port out_last, output, 1 bit: the out_valid entry is the final entry of the block.
REQ-015 SHALL have port out_tag, output, SEL_W bits: latched tag, aligned with out_valid.
REQ-016 SHALL have port busy, output, 1 bit: high in RUN and DRAIN.
REQ-017 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-018 SHALL have port err_cfg, output, 1 bit: one-cycle pulse for a start with phase_en == 0.

Function
REQ-019 Phase base/length (R = NUM_PIXEL+8): INT_ROW base 0, len R; INT_COL base R, len NUM_PIXEL; HALF_A base R+NUM_PIXEL; HALF_B base R+2*NUM_PIXEL; HALF_C base R+3*NUM_PIXEL; each HALF phase len NUM_PIXEL. Defaults: 0/16, 16/8, 24/8, 32/8, 40/8.
REQ-020 FSM SHALL have states IDLE, RUN, DRAIN.
REQ-021 IDLE transitions:
- start with phase_en != 0: latch phase_en and tag_in; go to RUN with sel = base of the lowest enabled phase.
- start with phase_en == 0: pulse err_cfg; stay in IDLE.
REQ-022 RUN SHALL hold sel_valid=1; an entry is accepted on a cycle where ready=1.
REQ-023 On accept, sel SHALL move as follows:
- not last index of phase: sel+1.
- last index of phase: base of the next higher enabled phase; disabled phases are skipped.
- no further enabled phase: go to DRAIN.
REQ-024 While ready=0, sel SHALL hold its value and no entry is counted or duplicated.
REQ-025 out_valid, out_phase, out_last and out_tag SHALL be registered from the accepted entry, so they appear exactly one cycle after acceptance and align with the mux's one-cycle output latency.
REQ-026 DRAIN lasts exactly one cycle, in which done=1; the FSM then returns to IDLE.
REQ-027 done SHALL coincide with out_valid=1 and out_last=1.
REQ-028 start SHALL be ignored while busy=1, and phase_en/tag_in changes during a block SHALL have no effect.
REQ-029 abort in RUN or DRAIN SHALL return the FSM to IDLE next cycle with sel=0, sel_valid=0 and no done pulse. An entry accepted in the abort cycle still produces its out_valid.
REQ-030 start and abort asserted together in IDLE: abort wins, the start is dropped and no err_cfg is raised.
REQ-031 The per-phase index counter SHALL be wide enough for R-1 and SHALL never exceed phase length-1.

Reset
REQ-032 When reset=0, the block SHALL asynchronously clear: FSM to IDLE; sel, out_phase and out_tag to 0; sel_valid, out_valid, out_last, busy, done and err_cfg to 0.
REQ-033 Reset asserted mid-block SHALL discard the block, and the next start SHALL begin from the first enabled base.

Structure
REQ-034 A shared package interp_pkg SHALL hold the phase code constants, the FSM state enum, and the base/length functions of NUM_PIXEL.
REQ-035 The next-enabled-phase search SHALL be a combinational sub-module interp_next_phase (inputs: phase_en, current phase; outputs: next phase, none_left).

Verification
REQ-036 phase_en=5'b11111, ready=1 constant, start at cycle 0 -> sel runs 0..47 on cycles 1..48; out_valid on cycles 2..49; out_last and done on cycle 49; busy=0 from cycle 50.
REQ-037 phase_en=5'b10100 -> sel runs 24..31 then 40..47 back-to-back; 16 out_valid pulses; out_phase 2 then 4.
REQ-038 ready=0 for 3 cycles while sel=5 -> sel holds 5 for 3 cycles; no out_valid during the stall; exactly one out_valid for entry 5 after ready returns.
REQ-039 start with phase_en=0 -> single err_cfg pulse; busy stays 0; sel_valid stays 0.
REQ-040 reset dropped while sel=20 -> all outputs 0 immediately. Separately, abort at sel=20 -> IDLE next cycle, no done pulse. A following start with 5'b00001 -> sel 0..15 with out_tag equal to the new tag.

Source files
------------

// File: rtl/interp_pkg.sv
// Shared definitions for the interpolation mux sequencer: phase codes, FSM
// states and the phase base/length geometry as a function of block width.
package interp_pkg;

  localparam int unsigned NUM_PHASES = 5;

  localparam logic [2:0] PH_INT_ROW = 3'd0;
  localparam logic [2:0] PH_INT_COL = 3'd1;
  localparam logic [2:0] PH_HALF_A  = 3'd2;
  localparam logic [2:0] PH_HALF_B  = 3'd3;
  localparam logic [2:0] PH_HALF_C  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // The row phase carries 8 extra filter-tap entries beyond the block width.
  function automatic int unsigned phase_len(input logic [2:0] ph, input int unsigned np);
    return (ph == PH_INT_ROW) ? np + 32'd8 : np;
  endfunction

  function automatic int unsigned phase_base(input logic [2:0] ph, input int unsigned np);
    int unsigned b;
    case (ph)
      PH_INT_ROW: b = 32'd0;
      PH_INT_COL: b = np + 32'd8;
      PH_HALF_A:  b = np + 32'd8 + np;
      PH_HALF_B:  b = np + 32'd8 + 32'd2 * np;
      PH_HALF_C:  b = np + 32'd8 + 32'd3 * np;
      default:    b = 32'd0;
    endcase
    return b;
  endfunction

  function automatic logic [2:0] first_phase(input logic [4:0] en);
    logic [2:0] r;
    r = PH_INT_ROW;
    for (int p = 4; p >= 0; p--) begin
      if (en[p]) r = 3'(p);
    end
    return r;
  endfunction

endpackage

// File: rtl/interp_next_phase.sv
// Finds the lowest enabled phase strictly above the current one.
module interp_next_phase
  import interp_pkg::*;
(
  input  logic [4:0] phase_en_i,
  input  logic [2:0] cur_phase_i,
  output logic [2:0] next_phase_o,
  output logic       none_left_o
);

  // Descending scan so the lowest qualifying phase is the last one written.
  always_comb begin
    next_phase_o = PH_INT_ROW;
    none_left_o  = 1'b1;
    for (int p = 4; p >= 0; p--) begin
      if (phase_en_i[p] && (p > int'(cur_phase_i))) begin
        next_phase_o = 3'(p);
        none_left_o  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/interp_mux_sequencer.sv
// Walks the enabled interpolation phases of one block, driving the input mux
// select under ready backpressure and tagging the registered mux output.
module interp_mux_sequencer
  import interp_pkg::*;
#(
  parameter int unsigned NUM_PIXEL = 8,
  parameter int unsigned SEL_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       phase_en,
  input  logic [SEL_W-1:0] tag_in,
  input  logic             abort,
  input  logic             ready,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  output logic             out_valid,
  output logic [2:0]       out_phase,
  output logic             out_last,
  output logic [SEL_W-1:0] out_tag,
  output logic             busy,
  output logic             done,
  output logic             err_cfg
);

  localparam int unsigned R_LEN = NUM_PIXEL + 8;
  localparam int unsigned IDX_W = (R_LEN > 1) ? $clog2(R_LEN) : 1;

  state_t           state_q, state_d;
  logic [4:0]       en_q, en_d;
  logic [SEL_W-1:0] tag_q, tag_d;
  logic [2:0]       phase_q, phase_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             sel_valid_q, sel_valid_d;
  logic             out_valid_q, out_valid_d;
  logic [2:0]       out_phase_q, out_phase_d;
  logic             out_last_q, out_last_d;
  logic [SEL_W-1:0] out_tag_q, out_tag_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [2:0] nxt_phase;
  logic       none_left;
  logic       idx_last;
  logic [2:0] start_phase;

  interp_next_phase u_next (
    .phase_en_i   (en_q),
    .cur_phase_i  (phase_q),
    .next_phase_o (nxt_phase),
    .none_left_o  (none_left)
  );

  assign idx_last    = (32'(idx_q) == phase_len(phase_q, NUM_PIXEL) - 32'd1);
  assign start_phase = first_phase(phase_en);

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    tag_d       = tag_q;
    phase_d     = phase_q;
    idx_d       = idx_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    out_valid_d = 1'b0;
    out_phase_d = out_phase_q;
    out_last_d  = 1'b0;
    out_tag_d   = out_tag_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // abort outranks start, including its config-error check
        if (!abort && start) begin
          if (phase_en == 5'd0) begin
            err_d = 1'b1;
          end else begin
            en_d        = phase_en;
            tag_d       = tag_in;
            phase_d     = start_phase;
            idx_d       = '0;
            sel_d       = SEL_W'(phase_base(start_phase, NUM_PIXEL));
            sel_valid_d = 1'b1;
            busy_d      = 1'b1;
            state_d     = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (ready) begin
          out_valid_d = 1'b1;
          out_phase_d = phase_q;
          out_tag_d   = tag_q;
          out_last_d  = idx_last && none_left;
          if (!idx_last) begin
            idx_d = idx_q + IDX_W'(1);
            sel_d = sel_q + SEL_W'(1);
          end else if (!none_left) begin
            phase_d = nxt_phase;
            idx_d   = '0;
            sel_d   = SEL_W'(phase_base(nxt_phase, NUM_PIXEL));
          end else begin
            state_d     = ST_DRAIN;
            sel_d       = '0;
            sel_valid_d = 1'b0;
            done_d      = 1'b1;
          end
        end
        if (abort) begin
          state_d     = ST_IDLE;
          sel_d       = '0;
          sel_valid_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b0;
        end
      end

      ST_DRAIN: begin
        state_d     = ST_IDLE;
        sel_d       = '0;
        sel_valid_d = 1'b0;
        busy_d      = 1'b0;
      end

      default: begin
        state_d     = ST_IDLE;
        sel_d       = '0;
        sel_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      en_q        <= '0;
      tag_q       <= '0;
      phase_q     <= PH_INT_ROW;
      idx_q       <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_phase_q <= '0;
      out_last_q  <= 1'b0;
      out_tag_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      tag_q       <= tag_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      out_valid_q <= out_valid_d;
      out_phase_q <= out_phase_d;
      out_last_q  <= out_last_d;
      out_tag_q   <= out_tag_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign out_valid = out_valid_q;
  assign out_phase = out_phase_q;
  assign out_last  = out_last_q;
  assign out_tag   = out_tag_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_cfg   = err_q;

endmodule
